// File: rtl/rpn_operand_stack_pkg.sv
// Shared opcodes, error codes and FSM states
// for the RPN operand stack.
package rpn_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_REDUCE = 3'b011;
  localparam logic [2:0] OP_SWAP   = 3'b100;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Command handshake between the keypad/ALU
// sequencer (master) and the stack (slave).
interface rpn_cmd_if #(
  parameter int W = 16
);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/rpn_stack_mem.sv
// DEPTH x W operand registers, one-hot writes,
// two one-hot AND-OR read ports. Macro: RPN_STACK_SWAP_EN.
module rpn_stack_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic [DEPTH-1:0] we_a,
  input  logic [W-1:0]     wd_a,
`ifdef RPN_STACK_SWAP_EN
  input  logic [DEPTH-1:0] we_b,
  input  logic [W-1:0]     wd_b,
`endif
  input  logic [DEPTH-1:0] rsel_a,
  input  logic [DEPTH-1:0] rsel_b,
  output logic [W-1:0]     rd_a,
  output logic [W-1:0]     rd_b
);

  logic [W-1:0] mem [DEPTH];

  // Load each entry on its one-hot enable; contents are not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we_a[i]) begin
        mem[i] <= wd_a;
      end
`ifdef RPN_STACK_SWAP_EN
      else if (we_b[i]) begin
        mem[i] <= wd_b;
      end
`endif
    end
  end

  // An all-zero select reads as 0, which masks tos/nos by depth
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_a = rd_a | ({W{rsel_a[i]}} & mem[i]);
      rd_b = rd_b | ({W{rsel_b[i]}} & mem[i]);
    end
  end

endmodule

// File: rtl/rpn_operand_stack.sv
// RPN operand stack controller: FSM, depth count, checks.
// Macro RPN_STACK_SWAP_EN enables op 100 SWAP.
module rpn_operand_stack
  import rpn_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  rpn_cmd_if.slave      cmd,
  output logic [W-1:0]  tos,
  output logic [W-1:0]  nos,
  output logic [AW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          err,
  output logic [1:0]    err_code,
  input  logic          err_clr
);

  state_t state, nxt_state;
  logic [AW-1:0] nxt_depth;
  logic [1:0]    nxt_code;

  logic acc;
  logic is_nop, is_push, is_pop, is_red;
`ifdef RPN_STACK_SWAP_EN
  logic is_swap;
  logic [DEPTH-1:0] we_b;
  logic [W-1:0]     wd_b;
`endif

  logic [DEPTH-1:0] sel_free;
  logic [DEPTH-1:0] sel_top;
  logic [DEPTH-1:0] sel_nxt;
  logic [DEPTH-1:0] we_a;
  logic [W-1:0]     wd_a;

  assign cmd.cmd_ready = (state == ST_RUN);
  // Writes are suppressed while reset is held so nothing lands mid-reset
  assign acc = cmd.cmd_valid & cmd.cmd_ready & rst_n;

  assign is_nop  = (cmd.cmd_op == OP_NOP);
  assign is_push = (cmd.cmd_op == OP_PUSH);
  assign is_pop  = (cmd.cmd_op == OP_POP);
  assign is_red  = (cmd.cmd_op == OP_REDUCE);
`ifdef RPN_STACK_SWAP_EN
  assign is_swap = (cmd.cmd_op == OP_SWAP);
`endif

  assign empty = (depth == '0);
  assign full  = (depth == AW'(DEPTH));
  assign err   = (state == ST_ERR);

  // One-hot decodes of entries depth, depth-1, depth-2
  always_comb begin
    sel_free = '0;
    sel_top  = '0;
    sel_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_free[i] = (int'(depth) == i);
      sel_top[i]  = (int'(depth) == i + 1);
      sel_nxt[i]  = (int'(depth) == i + 2);
    end
  end

  // Next-state, depth update, error capture and write enables
  always_comb begin
    nxt_state = state;
    nxt_depth = depth;
    nxt_code  = err_code;
    we_a      = '0;
    wd_a      = cmd.cmd_data;
`ifdef RPN_STACK_SWAP_EN
    we_b      = '0;
    wd_b      = tos;
`endif
    unique case (state)
      ST_RUN: begin
        if (acc) begin
          unique case (1'b1)
            is_nop: begin
            end
            is_push: begin
              if (full) begin
                nxt_state = ST_ERR;
                nxt_code  = ERR_OVF;
              end else begin
                we_a      = sel_free;
                nxt_depth = depth + AW'(1);
              end
            end
            is_pop: begin
              if (empty) begin
                nxt_state = ST_ERR;
                nxt_code  = ERR_UNF;
              end else begin
                nxt_depth = depth - AW'(1);
              end
            end
            is_red: begin
              if (depth < AW'(2)) begin
                nxt_state = ST_ERR;
                nxt_code  = ERR_UNF;
              end else begin
                we_a      = sel_nxt;
                nxt_depth = depth - AW'(1);
              end
            end
`ifdef RPN_STACK_SWAP_EN
            is_swap: begin
              if (depth < AW'(2)) begin
                nxt_state = ST_ERR;
                nxt_code  = ERR_UNF;
              end else begin
                we_a = sel_top;
                wd_a = nos;
                we_b = sel_nxt;
              end
            end
`endif
            default: begin
              nxt_state = ST_ERR;
              nxt_code  = ERR_ILL;
            end
          endcase
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          nxt_state = ST_RUN;
          nxt_code  = ERR_NONE;
        end
      end
      default: begin
        nxt_state = ST_RUN;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      depth    <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= nxt_state;
      depth    <= nxt_depth;
      err_code <= nxt_code;
    end
  end

  rpn_stack_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_a   (we_a),
    .wd_a   (wd_a),
`ifdef RPN_STACK_SWAP_EN
    .we_b   (we_b),
    .wd_b   (wd_b),
`endif
    .rsel_a (sel_top),
    .rsel_b (sel_nxt),
    .rd_a   (tos),
    .rd_b   (nos)
  );

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Scoreboard bench for rpn_operand_stack.
// Directed vectors, queued expectations.
module tb_rpn_operand_stack;
  import rpn_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH + 1);

  typedef struct {
    string       tag;
    int          d;
    logic [15:0] t;
    logic [15:0] n;
    logic        e;
    logic [1:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic [W-1:0]  tos, nos;
  logic [AW-1:0] depth;
  logic empty, full, err;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  event mon_ev;

  rpn_cmd_if #(.W(W)) cmd_if ();

  rpn_operand_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_if),
    .tos      (tos),
    .nos      (nos),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .err      (err),
    .err_code (err_code),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation
  initial begin
    exp_t x;
    logic xe, xf, xr;
    forever begin
      @(negedge clk or mon_ev);
      while (q.size() > 0) begin
        x = q.pop_front();
        xe = (x.d == 0);
        xf = (x.d == DEPTH);
        xr = !x.e;
        vectors++;
        if (int'(depth) != x.d || tos !== x.t ||
            nos !== x.n || empty !== xe ||
            full !== xf || err !== x.e ||
            err_code !== x.c ||
            cmd_if.cmd_ready !== xr) begin
          miscompares++;
          $display("FAIL %s: got d=%0d tos=%h nos=%h emp=%b ful=%b err=%b code=%b rdy=%b want d=%0d tos=%h nos=%h emp=%b ful=%b err=%b code=%b rdy=%b",
                   x.tag, depth, tos, nos, empty, full,
                   err, err_code, cmd_if.cmd_ready,
                   x.d, x.t, x.n, xe, xf, x.e, x.c, xr);
        end
      end
    end
  end

  task automatic expect_now(
    input string tag, input int d,
    input logic [15:0] t, input logic [15:0] n,
    input logic e, input logic [1:0] c
  );
    exp_t x;
    x.tag = tag; x.d = d; x.t = t;
    x.n = n; x.e = e; x.c = c;
    q.push_back(x);
  endtask

  task automatic cmd(
    input logic v, input logic [2:0] op,
    input logic [15:0] dat, input logic clr,
    input string tag, input int d,
    input logic [15:0] t, input logic [15:0] n,
    input logic e, input logic [1:0] c
  );
    @(negedge clk);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = dat;
    err_clr          = clr;
    @(posedge clk);
    #1;
    expect_now(tag, d, t, n, e, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    err_clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] st, sn;
    logic        se;
    logic [1:0]  sc;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = '0;
    #2;
    expect_now("reset", 0, 16'h0, 16'h0, 0, ERR_NONE);
    -> mon_ev;
    @(negedge clk);
    rst_n = 1'b1;

    // 1) three pushes
    cmd(1, OP_PUSH, 16'h0011, 0, "push1", 1, 16'h0011, 16'h0000, 0, 0);
    cmd(1, OP_PUSH, 16'h0022, 0, "push2", 2, 16'h0022, 16'h0011, 0, 0);
    cmd(1, OP_PUSH, 16'h0033, 0, "push3", 3, 16'h0033, 16'h0022, 0, 0);

    // 2) reduce, pop, pop
    cmd(1, OP_REDUCE, 16'h0055, 0, "reduce", 2, 16'h0055, 16'h0011, 0, 0);
    cmd(1, OP_POP, 16'h0, 0, "pop1", 1, 16'h0011, 16'h0000, 0, 0);
    cmd(1, OP_POP, 16'h0, 0, "pop2", 0, 16'h0000, 16'h0000, 0, 0);

    // 3) fill, overflow, hold, clear
    for (int k = 1; k <= DEPTH; k++) begin
      cmd(1, OP_PUSH, 16'h0100 + 16'(k - 1), 0, "fill", k,
          16'h0100 + 16'(k - 1),
          (k >= 2) ? 16'h0100 + 16'(k - 2) : 16'h0, 0, 0);
    end
    cmd(1, OP_PUSH, 16'hBEEF, 0, "ovf", 8, 16'h0107, 16'h0106, 1, ERR_OVF);
    cmd(1, OP_POP, 16'h0, 0, "ovf_hold", 8, 16'h0107, 16'h0106, 1, ERR_OVF);
    cmd(0, OP_NOP, 16'h0, 1, "ovf_clr", 8, 16'h0107, 16'h0106, 0, ERR_NONE);
    cmd(1, OP_POP, 16'h0, 0, "pop_full", 7, 16'h0106, 16'h0105, 0, 0);

    // 4) underflow, clear with command held
    do_reset();
    cmd(1, OP_POP, 16'h0, 0, "unf_pop", 0, 16'h0, 16'h0, 1, ERR_UNF);
    cmd(1, OP_PUSH, 16'h0066, 1, "clr_cmd", 0, 16'h0, 16'h0, 0, ERR_NONE);
    cmd(0, OP_NOP, 16'h0, 0, "idle", 0, 16'h0, 16'h0, 0, ERR_NONE);
    cmd(1, OP_PUSH, 16'h0077, 0, "push77", 1, 16'h0077, 16'h0, 0, 0);

    // 5) reduce underflow, illegal ops, swap
    cmd(1, OP_REDUCE, 16'h0099, 0, "unf_red", 1, 16'h0077, 16'h0, 1, ERR_UNF);
    cmd(0, OP_NOP, 16'h0, 1, "clr1", 1, 16'h0077, 16'h0, 0, 0);
    cmd(1, 3'b101, 16'h0, 0, "ill101", 1, 16'h0077, 16'h0, 1, ERR_ILL);
    cmd(0, OP_NOP, 16'h0, 1, "clr2", 1, 16'h0077, 16'h0, 0, 0);
    cmd(1, OP_PUSH, 16'h0088, 0, "push88", 2, 16'h0088, 16'h0077, 0, 0);
`ifdef RPN_STACK_SWAP_EN
    st = 16'h0077; sn = 16'h0088; se = 1'b0; sc = ERR_NONE;
`else
    st = 16'h0088; sn = 16'h0077; se = 1'b1; sc = ERR_ILL;
`endif
    cmd(1, OP_SWAP, 16'h0, 0, "op100", 2, st, sn, se, sc);
    cmd(0, OP_NOP, 16'h0, 1, "clr3", 2, st, sn, 0, 0);
    cmd(1, 3'b111, 16'h0, 0, "ill111", 2, st, sn, 1, ERR_ILL);
    cmd(0, OP_NOP, 16'h0, 1, "clr4", 2, st, sn, 0, 0);

    // 6) async reset mid-push at depth 5
    cmd(1, OP_PUSH, 16'h0501, 0, "d3", 3, 16'h0501, st, 0, 0);
    cmd(1, OP_PUSH, 16'h0502, 0, "d4", 4, 16'h0502, 16'h0501, 0, 0);
    cmd(1, OP_PUSH, 16'h0503, 0, "d5", 5, 16'h0503, 16'h0502, 0, 0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_PUSH;
    cmd_if.cmd_data  = 16'h0600;
    err_clr          = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", 0, 16'h0, 16'h0, 0, ERR_NONE);
    -> mon_ev;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    cmd(0, OP_NOP, 16'h0, 0, "post_rst", 0, 16'h0, 16'h0, 0, 0);
    cmd(1, OP_PUSH, 16'h0700, 0, "post_push", 1, 16'h0700, 16'h0, 0, 0);

    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
